// File: rtl/rf_wb_scheduler_pkg.sv
// Shared widths, defaults and types for the register-file writeback scheduler.
package rf_wb_scheduler_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int MAX_OUT_DEF  = 4;
  localparam int CNT_W        = 5;   // holds 0..31 outstanding ops
  localparam int WAIT_W       = 4;   // holds 0..15 refused cycles

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB0,
    GNT_WB1
  } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations plus the outstanding
// long-op counter that throttles issue.
module rf_scoreboard
  import rf_wb_scheduler_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en_i,
  input  reg_addr_t set_rd_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_rd_i,
  input  reg_addr_t rs_i,
  input  reg_addr_t rt_i,
  input  reg_addr_t rd_i,
  input  logic      inc_i,
  input  logic      dec_i,
  output logic      rs_pend_o,
  output logic      rt_pend_o,
  output logic      rd_pend_o,
  output logic      full_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a missed branch silently infers a latch.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_rd_i] = 1'b0;
    // Set is applied after clear so a same-cycle reissue to the same rd wins.
    if (set_en_i && (set_rd_i != '0)) pend_d[set_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: the pending vector is state the hazard logic trusts, so unlike a data
  // RAM it must be reset; a stale bit would stall ID forever.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rs_pend_o = pend_q[rs_i];
  assign rt_pend_o = pend_q[rt_i];
  assign rd_pend_o = pend_q[rd_i];
  assign full_o    = (cnt_q == CNT_W'(MAX_OUT));

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between pipeline WB and the
// MUL/DIV unit, tracks long-latency hazards and forces a WB bubble on starvation.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int MAX_OUT  = MAX_OUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  input  logic [4:0]  chk_rd,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  output logic        raw_stall,
  output logic        waw_stall,
  output logic        lu_full,
  output logic        wb_stall,
  output logic        regWr,
  output logic [4:0]  WrReg,
  output logic [31:0] WriteData
);

  // With MAX_WAIT=1 the bubble can come no earlier than the second refusal.
  localparam int                WAIT_SAT_I = (MAX_WAIT > 1) ? MAX_WAIT - 1 : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(WAIT_SAT_I);

  gnt_e              gnt;
  logic              long_issue, wb1_xfer;
  logic              rs_pend, rt_pend;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wb_stall_q, wb_stall_d;

  assign wb1_ready  = !wb0_valid;
  assign wb1_xfer   = wb1_valid && wb1_ready;
  assign long_issue = iss_valid && iss_long;

  always_comb begin
    gnt = GNT_NONE;
    if (wb0_valid)      gnt = GNT_WB0;
    else if (wb1_valid) gnt = GNT_WB1;
  end

  always_comb begin
    regWr     = 1'b0;
    WrReg     = '0;
    WriteData = '0;
    unique case (gnt)
      GNT_WB0: begin
        regWr     = 1'b1;
        WrReg     = wb0_rd;
        WriteData = wb0_data;
      end
      GNT_WB1: begin
        regWr     = 1'b1;
        WrReg     = wb1_rd;
        WriteData = wb1_data;
      end
      default: ;
    endcase
  end

  // Refused cycles are counted up to a saturation point; the bubble request is
  // raised only on the transition into saturation so it lasts one cycle.
  always_comb begin
    wait_d     = wait_q;
    wb_stall_d = 1'b0;
    if (!wb1_valid || wb1_xfer) begin
      wait_d = '0;
    end else if (wait_q != WAIT_SAT) begin
      wait_d     = wait_q + WAIT_W'(1);
      wb_stall_d = (wait_d == WAIT_SAT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign wb_stall  = wb_stall_q;
  assign raw_stall = rs_pend || rt_pend;

  rf_scoreboard #(
    .MAX_OUT (MAX_OUT)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (long_issue),
    .set_rd_i  (iss_rd),
    .clr_en_i  (wb1_xfer),
    .clr_rd_i  (wb1_rd),
    .rs_i      (chk_rs),
    .rt_i      (chk_rt),
    .rd_i      (chk_rd),
    .inc_i     (long_issue),
    .dec_i     (wb1_xfer),
    .rs_pend_o (rs_pend),
    .rt_pend_o (rt_pend),
    .rd_pend_o (waw_stall),
    .full_o    (lu_full)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (MAX_WAIT=4, MAX_OUT=4).
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd, chk_rs, chk_rt, chk_rd;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb1_ready, raw_stall, waw_stall, lu_full, wb_stall, regWr;
  logic [4:0]  WrReg;
  logic [31:0] WriteData;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(
    .MAX_WAIT (4),
    .MAX_OUT  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .chk_rd    (chk_rd),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .raw_stall (raw_stall),
    .waw_stall (waw_stall),
    .lu_full   (lu_full),
    .wb_stall  (wb_stall),
    .regWr     (regWr),
    .WrReg     (WrReg),
    .WriteData (WriteData)
  );

  // A long issue into a full unit is illegal unless a retirement frees a slot
  // in the same cycle.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(iss_valid && iss_long && lu_full && !(wb1_valid && wb1_ready)))
        else $error("protocol: long issue while lu_full");
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0;
    chk_rs = '0; chk_rt = '0; chk_rd = '0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = rd;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    check("rst_regWr",     32'(regWr),     32'd0);
    check("rst_WrReg",     32'(WrReg),     32'd0);
    check("rst_WriteData", WriteData,      32'd0);
    check("rst_wb1_ready", 32'(wb1_ready), 32'd1);
    check("rst_raw",       32'(raw_stall), 32'd0);
    check("rst_lu_full",   32'(lu_full),   32'd0);
    check("rst_wb_stall",  32'(wb_stall),  32'd0);
    cyc(); rst_n = 1'b1;

    // RAW/WAW window on rd=5
    cyc(); issue_long(5'd5); chk_rs = 5'd5; chk_rd = 5'd5; settle();
    check("raw_before_set", 32'(raw_stall), 32'd0);
    cyc(); iss_valid = 1'b0; iss_long = 1'b0; settle();
    check("raw_rs5", 32'(raw_stall), 32'd1);
    check("waw_rd5", 32'(waw_stall), 32'd1);
    chk_rs = 5'd0; chk_rt = 5'd5; #1;
    check("raw_rt5", 32'(raw_stall), 32'd1);
    cyc(); wb1_valid = 1'b1; wb1_rd = 5'd5; wb1_data = 32'hDEAD_BEEF; settle();
    check("wb1_only_regWr", 32'(regWr),     32'd1);
    check("wb1_only_WrReg", 32'(WrReg),     32'd5);
    check("wb1_only_data",  WriteData,      32'hDEAD_BEEF);
    check("wb1_only_ready", 32'(wb1_ready), 32'd1);
    check("raw_xfer_cycle", 32'(raw_stall), 32'd1);
    check("waw_xfer_cycle", 32'(waw_stall), 32'd1);
    cyc(); wb1_valid = 1'b0; settle();
    check("raw_cleared",  32'(raw_stall), 32'd0);
    check("waw_cleared",  32'(waw_stall), 32'd0);
    check("idle_regWr",   32'(regWr),     32'd0);
    check("idle_WrReg",   32'(WrReg),     32'd0);
    check("idle_data",    WriteData,      32'd0);

    // wb0 beats wb1; wb1 goes next
    cyc(); idle(); issue_long(5'd7);
    cyc(); iss_valid = 1'b0; iss_long = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'hAAAA_0001;
    wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h1234_5678; settle();
    check("both_regWr", 32'(regWr),     32'd1);
    check("both_WrReg", 32'(WrReg),     32'd3);
    check("both_data",  WriteData,      32'hAAAA_0001);
    check("both_ready", 32'(wb1_ready), 32'd0);
    cyc(); wb0_valid = 1'b0; settle();
    check("next_WrReg", 32'(WrReg),     32'd7);
    check("next_data",  WriteData,      32'h1234_5678);
    check("next_ready", 32'(wb1_ready), 32'd1);
    cyc(); idle();

    // Starvation: bubble requested in the 4th refused cycle
    cyc(); issue_long(5'd10);
    for (int i = 0; i < 4; i++) begin
      cyc(); iss_valid = 1'b0; iss_long = 1'b0;
      wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'(i);
      wb1_valid = 1'b1; wb1_rd = 5'd10; wb1_data = 32'hCAFE_0010; settle();
      check($sformatf("starve_wb_stall_%0d", i), 32'(wb_stall), 32'(i == 3));
      check($sformatf("starve_ready_%0d", i), 32'(wb1_ready), 32'd0);
    end
    cyc(); wb0_valid = 1'b0; settle();
    check("bubble_wb_stall", 32'(wb_stall),  32'd0);
    check("bubble_ready",    32'(wb1_ready), 32'd1);
    check("bubble_WrReg",    32'(WrReg),     32'd10);
    check("bubble_data",     WriteData,      32'hCAFE_0010);
    cyc(); idle(); chk_rs = 5'd10; settle();
    check("post_bubble_wb_stall", 32'(wb_stall),  32'd0);
    check("post_bubble_raw",      32'(raw_stall), 32'd0);

    // Outstanding limit
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); issue_long(5'(11 + i)); settle();
      check($sformatf("fill_lu_full_%0d", i), 32'(lu_full), 32'd0);
    end
    cyc(); idle(); settle();
    check("full_after_4", 32'(lu_full), 32'd1);
    cyc(); issue_long(5'd15); wb1_valid = 1'b1; wb1_rd = 5'd11; wb1_data = 32'h11; settle();
    check("swap_lu_full", 32'(lu_full), 32'd1);
    cyc(); idle(); chk_rs = 5'd11; settle();
    check("swap_still_full", 32'(lu_full),   32'd1);
    check("swap_rd11_clear", 32'(raw_stall), 32'd0);
    chk_rs = 5'd15; #1;
    check("swap_rd15_set", 32'(raw_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); wb1_valid = 1'b1; wb1_rd = 5'(12 + i); settle();
      check($sformatf("drain_lu_full_%0d", i), 32'(lu_full), 32'(i == 0));
    end
    cyc(); idle(); settle();
    check("drained_lu_full", 32'(lu_full), 32'd0);

    // rd=0 counts but never pends; set wins over same-cycle clear
    cyc(); issue_long(5'd0);
    cyc(); issue_long(5'd9);
    cyc(); issue_long(5'd16);
    cyc(); issue_long(5'd9); wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h9; settle();
    cyc(); idle(); chk_rs = 5'd9; settle();
    check("set_wins_rd9", 32'(raw_stall), 32'd1);
    chk_rs = 5'd0; #1;
    check("rd0_not_pending", 32'(raw_stall), 32'd0);
    check("count3_not_full", 32'(lu_full),   32'd0);
    cyc(); issue_long(5'd17); settle();
    cyc(); idle(); settle();
    check("rd0_counted_full", 32'(lu_full), 32'd1);

    // Asynchronous reset mid-run with pending bits 9, 16, 17 set
    cyc(); #2 rst_n = 1'b0; #1;
    for (int r = 0; r < 32; r++) begin
      chk_rs = 5'(r); #1;
      check($sformatf("midrst_raw_%0d", r), 32'(raw_stall), 32'd0);
    end
    chk_rd = 5'd17; #1;
    check("midrst_waw",       32'(waw_stall), 32'd0);
    check("midrst_lu_full",   32'(lu_full),   32'd0);
    check("midrst_wb_stall",  32'(wb_stall),  32'd0);
    check("midrst_regWr",     32'(regWr),     32'd0);
    check("midrst_wb1_ready", 32'(wb1_ready), 32'd1);
    cyc(); rst_n = 1'b1;
    cyc(); chk_rs = 5'd17; settle();
    check("post_rst_raw17", 32'(raw_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Schedules the single register-file write port between the in-order pipeline writeback (WB stage) and the multi-cycle MUL/DIV unit writeback. It holds a 32-entry scoreboard of registers with outstanding long-latency writes, and raises RAW/WAW stall requests to the hazard logic. It also prevents starvation of the long-latency unit by forcing a single WB bubble. It sits between the WB stage, the MUL/DIV unit and the register file write port (regWr/WrReg/WriteData).

Parameters:
MAX_WAIT, 4, cycles a pending long-unit write may be refused before a WB bubble is forced (range 1..15)
MAX_OUT, 4, maximum outstanding long-latency operations (range 1..31)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
iss_valid  in  1  instruction issuing from ID this cycle (already stall-free)
iss_long  in  1  issuing instruction writes via MUL/DIV unit
iss_rd  in  5  destination of issuing instruction
chk_rs  in  5  ID-stage source register 1
chk_rt  in  5  ID-stage source register 2
chk_rd  in  5  ID-stage destination register
wb0_valid  in  1  pipeline WB write request (always accepted)
wb0_rd  in  5  pipeline WB destination
wb0_data  in  32  pipeline WB data
wb1_valid  in  1  MUL/DIV write request
wb1_rd  in  5  MUL/DIV destination
wb1_data  in  32  MUL/DIV data
wb1_ready  out  1  MUL/DIV write accepted this cycle
raw_stall  out  1  chk_rs or chk_rt has a pending long write
waw_stall  out  1  chk_rd has a pending long write
lu_full  out  1  outstanding count == MAX_OUT; ID must not issue long ops
wb_stall  out  1  pipeline must insert a WB bubble next cycle
regWr  out  1  register file write enable
WrReg  out  5  register file write address
WriteData  out  32  register file write data

Behaviour:
- Clock/reset: one clock domain; reset is asynchronous and active-low (rst_n). On reset, all pending bits, the outstanding counter, the wait counter and wb_stall clear to 0. Combinational outputs follow: wb1_ready=!wb0_valid, and stall flags are 0.
- Write-port mux (combinational, zero latency):
  - wb0_valid=1: regWr=1, WrReg=wb0_rd, WriteData=wb0_data, wb1_ready=0.
  - Otherwise wb1_ready=1. If wb1_valid, regWr=1 and the write drives wb1_rd/wb1_data; if not, regWr=0 and WrReg/WriteData=0.
  - An accepted write is a grant. Writes to rd 0 are passed through; the register file ignores them.
- Handshake: wb1 holds valid/rd/data stable until wb1_ready; a transfer occurs when wb1_valid & wb1_ready.
- Scoreboard pending[31:0]:
  - Set: bit iss_rd sets when iss_valid & iss_long & iss_rd!=0.
  - Clear: bit wb1_rd clears on a wb1 transfer.
  - Same rd set and cleared in one cycle: set wins.
  - pending[0] is constant 0.
- Stall flags (combinational):
  - raw_stall = pending[chk_rs] | pending[chk_rt].
  - waw_stall = pending[chk_rd].
- Outstanding counter (0..MAX_OUT):
  - +1 on a long issue; -1 on a wb1 transfer; unchanged when both occur.
  - lu_full = (count==MAX_OUT). A long issue while lu_full is a protocol violation; the bench asserts it never happens.
- Starvation control:
  - wait_cnt increments each cycle with wb1_valid & !wb1_ready, and clears on a transfer or when wb1_valid=0.
  - When wait_cnt reaches MAX_WAIT-1 while still refused, wb_stall is registered to 1 for exactly one cycle. The pipeline guarantees wb0_valid=0 in the cycle after wb_stall=1, so wb1 is granted there.
  - wait_cnt saturates and does not re-trigger until it clears.
- Reset mid-operation: all pending bits are lost. The MUL/DIV unit is reset by the same rst_n, so no stale wb1 write follows.

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and MAX_WAIT/MAX_OUT defaults.
- Sub-module rf_scoreboard: pending bits plus outstanding counter, with set/clear/lookup ports.
- Mux and starvation logic stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-run with pending bits set -> all outputs 0, raw_stall=0 for every chk_rs.
- Issue long op to rd=5, then chk_rs=5 -> raw_stall=1 until the cycle after the wb1 transfer of rd=5.
  - Also chk_rd=5 -> waw_stall=1 over the same window.
- Simultaneous wb0 (rd=3, 0xAAAA_0001) and wb1 (rd=7, 0x1234_5678) -> regWr with WrReg=3 and wb1_ready=0.
  - Next cycle, with wb0 idle -> WrReg=7, WriteData=0x1234_5678.
- wb0_valid held high, wb1_valid high, MAX_WAIT=4 -> wb_stall=1 in exactly one cycle (the 4th refused cycle).
  - With wb0 bubble next cycle -> wb1 granted.
- Issue 4 long ops (MAX_OUT=4) -> lu_full=1.
  - One wb1 transfer plus a simultaneous new long issue -> lu_full stays 1, counter stays 4.
- Long issue rd=0 -> no pending bit set, counter increments. Also: same-cycle issue rd=9 with wb1 transfer rd=9 -> pending[9]=1 afterwards.
